// File: rtl/attn_score_collect_pkg.sv
// Shared attention-datapath definitions: score type, most-negative score,
// the 1/sqrt(d) shift for a 64-wide head and the collector state encoding.
package attn_score_collect_pkg;

   localparam int SCORE_W = 16;

   typedef logic signed [SCORE_W-1:0] score_t;

   localparam score_t SCORE_MIN = 16'sh8000;

   // 1/sqrt(64) = 1/8, implemented as an arithmetic shift of log2(64)/2
   localparam int HEAD_DIM        = 64;
   localparam int SCALE_SHIFT_D64 = $clog2(HEAD_DIM) / 2;

   typedef enum logic {FILL, DRAIN} state_t;

endpackage

// File: rtl/score_align_pipe.sv
// Fixed-depth 1-bit valid delay line that tracks when an issued operation
// emerges from a fixed-latency pipeline.
module score_align_pipe #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   output logic out_valid
);

   logic [LAT-1:0] shift_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
      end else begin
         shift_q[0] <= in_valid;
         for (int i = 1; i < LAT; i++) begin
            shift_q[i] <= shift_q[i-1];
         end
      end
   end

   assign out_valid = shift_q[LAT-1];

endmodule

// File: rtl/attn_score_collect.sv
// Collects one row of Q.K scores from the dot-product stage, scales them by
// 1/sqrt(d), tracks the row maximum and streams the row to softmax.
module attn_score_collect
   import attn_score_collect_pkg::*;
#(
   parameter int DATA_W      = SCORE_W,
   parameter int NUM_KEYS    = 8,
   parameter int PIPE_LAT    = 3,
   parameter int SCALE_SHIFT = SCALE_SHIFT_D64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [DATA_W-1:0] score_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_score,
   output logic              out_last,
   output logic [DATA_W-1:0] out_max,
   output logic              busy
);

   localparam int CNT_W = $clog2(NUM_KEYS + 1);
   localparam int IDX_W = $clog2(NUM_KEYS);
   localparam logic [DATA_W-1:0] MOST_NEG = {SCORE_MIN[SCORE_W-1], {(DATA_W-1){1'b0}}};

   state_t                    state;
   logic [CNT_W-1:0]          iss_cnt;
   logic [CNT_W-1:0]          wr_cnt;
   logic [IDX_W-1:0]          rd_cnt;
   logic signed [DATA_W-1:0]  max_q;
   logic signed [DATA_W-1:0]  score_buf [NUM_KEYS];
   logic                      accept;
   logic                      cap_en;
   logic                      capture;
   logic                      xfer;
   logic signed [DATA_W-1:0]  scaled;

   assign issue_ready = (state == FILL) && (iss_cnt < CNT_W'(NUM_KEYS));
   assign accept      = issue_valid && issue_ready;
   assign capture     = cap_en && (state == FILL);
   assign xfer        = out_valid && out_ready;
   assign scaled      = $signed(score_in) >>> SCALE_SHIFT;

   score_align_pipe #(
      .LAT (PIPE_LAT)
   ) u_align (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (accept),
      .out_valid (cap_en)
   );

   // The row ends on the transfer of the last score: counters clear and the
   // maximum reloads so the next row starts from a clean slate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FILL;
         iss_cnt <= '0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         max_q   <= MOST_NEG;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  iss_cnt <= iss_cnt + 1'b1;
               end
               if (capture) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (scaled > max_q) begin
                     max_q <= scaled;
                  end
                  if (wr_cnt == CNT_W'(NUM_KEYS - 1)) begin
                     state  <= DRAIN;
                     rd_cnt <= '0;
                  end
               end
            end
            DRAIN: begin
               if (xfer) begin
                  if (rd_cnt == IDX_W'(NUM_KEYS - 1)) begin
                     state   <= FILL;
                     iss_cnt <= '0;
                     wr_cnt  <= '0;
                     rd_cnt  <= '0;
                     max_q   <= MOST_NEG;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         score_buf[wr_cnt[IDX_W-1:0]] <= scaled;
      end
   end

   assign out_valid = (state == DRAIN);
   assign out_score = out_valid ? score_buf[rd_cnt] : '0;
   assign out_last  = out_valid && (rd_cnt == IDX_W'(NUM_KEYS - 1));
   assign out_max   = max_q;
   assign busy      = !((state == FILL) && (iss_cnt == '0) && (wr_cnt == '0));

endmodule
